disp_scan: RTL

DISP_SCAN -- requirements
Module: disp_scan

---
 rtl/disp_pkg.sv | 29 ++
 rtl/hex7seg.sv | 33 +++
 rtl/disp_scan.sv | 126 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the board display scanner: source-select encodings
// and active-low seven-segment codes (bit 7 = dp, held off at 1).
package disp_pkg;

    localparam logic [2:0] SEL_PC    = 3'd0;
    localparam logic [2:0] SEL_IR    = 3'd1;
    localparam logic [2:0] SEL_F     = 3'd2;
    localparam logic [2:0] SEL_MDR   = 3'd3;
    localparam logic [2:0] SEL_WDATA = 3'd4;
    localparam logic [2:0] SEL_FLAGS = 3'd5;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low g..a segment decoder.
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Look up the segment pattern for the nibble value.
    always_comb begin
        seg = SEG_0[6:0];
        case (nib)
            4'h0: seg = SEG_0[6:0];
            4'h1: seg = SEG_1[6:0];
            4'h2: seg = SEG_2[6:0];
            4'h3: seg = SEG_3[6:0];
            4'h4: seg = SEG_4[6:0];
            4'h5: seg = SEG_5[6:0];
            4'h6: seg = SEG_6[6:0];
            4'h7: seg = SEG_7[6:0];
            4'h8: seg = SEG_8[6:0];
            4'h9: seg = SEG_9[6:0];
            4'hA: seg = SEG_A[6:0];
            4'hB: seg = SEG_B[6:0];
            4'hC: seg = SEG_C[6:0];
            4'hD: seg = SEG_D[6:0];
            4'hE: seg = SEG_E[6:0];
            4'hF: seg = SEG_F[6:0];
            default: seg = SEG_0[6:0];
        endcase
    end

endmodule

// File: rtl/disp_scan.sv
// Eight-digit multiplexed seven-segment scanner for a debug board. A free
// running prescaler paces the digit scan; each frame of eight digits is
// drawn from a single snapshot of the selected source and the flags.
module disp_scan
    import disp_pkg::*;
#(
    parameter int DIV_W    = 17,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [2:0]  sel,
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic [31:0] f,
    input  logic [31:0] mdr,
    input  logic [31:0] w_data,
    input  logic [3:0]  flags,
    output logic [7:0]  AN,
    output logic [7:0]  Seg
);

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      snap_v_q, snap_v_d;
    logic [3:0]       snap_f_q, snap_f_d;
    logic             tick_dly_q, tick_dly_d;
    logic             prime_q, prime_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;

    logic             tick;
    logic [2:0]       shown_idx;
    logic [3:0]       nib;
    logic [6:0]       hex_seg;
    logic [31:0]      src_val;
    logic [31:0]      upper;
    logic             lz_zero;
    logic             dp_on;

    assign tick = &cnt_q;

    // The index has already advanced when the delayed tick arrives, so the
    // digit being committed is the one that was current at the tick.
    assign shown_idx = idx_q - 3'd1;
    assign nib       = snap_v_q[{shown_idx, 2'b00} +: 4];
    assign upper     = snap_v_q >> {shown_idx, 2'b00};
    assign lz_zero   = (upper == 32'h0) && (shown_idx != 3'd0);
    assign dp_on     = ~shown_idx[2] & snap_f_q[shown_idx[1:0]];

    hex7seg u_hex7seg (
        .nib (nib),
        .seg (hex_seg)
    );

    // Source multiplexer for the snapshot.
    always_comb begin
        src_val = 32'h0;
        case (sel)
            SEL_PC:    src_val = pc;
            SEL_IR:    src_val = ir;
            SEL_F:     src_val = f;
            SEL_MDR:   src_val = mdr;
            SEL_WDATA: src_val = w_data;
            SEL_FLAGS: src_val = {28'h0, flags};
            default:   src_val = 32'h0;
        endcase
    end

    // Next-state logic for prescaler, scan index, snapshot and display.
    always_comb begin
        cnt_d      = cnt_q + CNT_ONE;
        idx_d      = tick ? idx_q + 3'd1 : idx_q;
        tick_dly_d = tick;
        prime_d    = 1'b1;
        snap_v_d   = snap_v_q;
        snap_f_d   = snap_f_q;
        an_d       = an_q;
        seg_d      = seg_q;

        // Reload on the edge that commits digit 7, so the old snapshot still
        // feeds that digit and the new one covers all of the next frame.
        if (!prime_q || (tick_dly_q && (idx_q == 3'd0))) begin
            snap_v_d = src_val;
            snap_f_d = flags;
        end

        if (tick_dly_q) begin
            an_d  = ~(8'b1 << shown_idx);
            seg_d = {~dp_on, hex_seg};
            if (BLANK_LZ && lz_zero) begin
                an_d  = 8'hFF;
                seg_d = 8'hFF;
            end
        end
    end

    // State registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            snap_v_q   <= 32'h0;
            snap_f_q   <= 4'h0;
            tick_dly_q <= 1'b0;
            prime_q    <= 1'b0;
            an_q       <= 8'hFF;
            seg_q      <= 8'hFF;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_v_q   <= snap_v_d;
            snap_f_q   <= snap_f_d;
            tick_dly_q <= tick_dly_d;
            prime_q    <= prime_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign AN  = an_q;
    assign Seg = seg_q;

endmodule
